// File: rtl/bcd_to_binary.sv
// Sequential 5-digit packed-BCD to 16-bit binary converter using reverse double-dabble.
// start/busy/done handshake; saturates on overflow and zeroes the result on a bad digit.
module bcd_to_binary #(
    parameter int DIGITS = 5,
    parameter int OUT_W  = 16,
    parameter int ITER   = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [OUT_W-1:0]      bin_out,
    output logic                  ovf,
    output logic                  err,
    output logic [1:0]            state_dbg
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + ITER;
    localparam int CNT_W  = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Handshake: start is honoured only in IDLE; busy covers acceptance through
    // completion; done is a single-cycle pulse on the cycle the results update.

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [WORK_W-1:0]   work, work_n;
    logic                err_q, err_q_n;
    logic                busy_n, done_n, ovf_n, err_n;
    logic [OUT_W-1:0]    bin_out_n;
    logic [WORK_W-1:0]   shifted;
    logic                bad_digit;
    logic [ITER-1:0]     result;

    assign state_dbg = state;
    assign result    = work[ITER-1:0];

    always_comb begin
        bad_digit = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_in[4*d +: 4] > 4'd9) bad_digit = 1'b1;
        end
    end

    // One shift step: digits are corrected independently, no borrow between them.
    always_comb begin
        shifted = work >> 1;
        for (int d = 0; d < DIGITS; d++) begin
            if (shifted[ITER + 4*d +: 4] >= 4'd8)
                shifted[ITER + 4*d +: 4] = shifted[ITER + 4*d +: 4] - 4'd3;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        work_n    = work;
        err_q_n   = err_q;
        busy_n    = busy;
        done_n    = 1'b0;
        bin_out_n = bin_out;
        ovf_n     = ovf;
        err_n     = err;
        case (state)
            IDLE: begin
                if (start) begin
                    work_n  = {bcd_in, {ITER{1'b0}}};
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                    err_q_n = bad_digit;
                    state_n = bad_digit ? FINISH : SHIFT;
                end
            end
            SHIFT: begin
                work_n = shifted;
                cnt_n  = cnt + CNT_W'(1);
                if (cnt == CNT_W'(ITER - 1)) state_n = FINISH;
            end
            FINISH: begin
                // A rejected input spends one extra edge here so it completes two edges after acceptance.
                if (err_q && cnt == '0) begin
                    cnt_n = CNT_W'(1);
                end else begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (err_q) begin
                        err_n     = 1'b1;
                        ovf_n     = 1'b0;
                        bin_out_n = '0;
                    end else if (result > ITER'({OUT_W{1'b1}})) begin
                        err_n     = 1'b0;
                        ovf_n     = 1'b1;
                        bin_out_n = '1;
                    end else begin
                        err_n     = 1'b0;
                        ovf_n     = 1'b0;
                        bin_out_n = result[OUT_W-1:0];
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            work    <= '0;
            err_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_out <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            work    <= work_n;
            err_q   <= err_q_n;
            busy    <= busy_n;
            done    <= done_n;
            bin_out <= bin_out_n;
            ovf     <= ovf_n;
            err     <= err_n;
        end
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary: latency, saturation, digit errors, handshake and reset.
module tb_bcd_to_binary;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [19:0] bcd_in;
    logic        busy, done, ovf, err;
    logic [15:0] bin_out;
    logic [1:0]  state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [19:0] V_BCD [6] = '{20'h00000, 20'h65535, 20'h01234, 20'h00042, 20'h65536, 20'h99999};
    localparam logic [15:0] V_BIN [6] = '{16'h0000, 16'hFFFF, 16'h04D2, 16'h002A, 16'hFFFF, 16'hFFFF};
    localparam logic        V_OVF [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    bcd_to_binary dut (
        .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
        .busy(busy), .done(done), .bin_out(bin_out), .ovf(ovf), .err(err),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Returns at the falling edge after the accepting edge; scrambles bcd_in afterwards.
    task automatic launch(input logic [19:0] b);
        @(negedge clk);
        bcd_in = b;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 20'hFFFFF;
    endtask

    // Counts edges after acceptance until done; -1 on timeout.
    task automatic wait_done(output int edges, output int busy_cyc);
        edges    = -1;
        busy_cyc = (busy === 1'b1) ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                edges = i;
                return;
            end
            if (busy === 1'b1) busy_cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bcd_in = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({busy, done, ovf, err} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {busy, done, ovf, err}); end
        n_cmp++; if (bin_out !== 16'h0) begin n_bad++; $display("FAIL reset_bin: got %h want 0000", bin_out); end
        n_cmp++; if (state_dbg !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
        rst = 1'b0;
    endtask

    task automatic test_convert();
        int edges, bcyc;
        for (int v = 0; v < 6; v++) begin
            launch(V_BCD[v]);
            wait_done(edges, bcyc);
            n_cmp++; if (edges !== 18) begin n_bad++; $display("FAIL conv_latency[%h]: got %0d want 18", V_BCD[v], edges); end
            n_cmp++; if (bcyc !== 18) begin n_bad++; $display("FAIL conv_busy_cycles[%h]: got %0d want 18", V_BCD[v], bcyc); end
            n_cmp++; if (bin_out !== V_BIN[v]) begin n_bad++; $display("FAIL conv_bin[%h]: got %h want %h", V_BCD[v], bin_out, V_BIN[v]); end
            n_cmp++; if (ovf !== V_OVF[v] || err !== 1'b0) begin n_bad++; $display("FAIL conv_flags[%h]: got ovf=%b err=%b want ovf=%b err=0", V_BCD[v], ovf, err, V_OVF[v]); end
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL conv_busy_at_done[%h]: got %b want 0", V_BCD[v], busy); end
            @(negedge clk);
            n_cmp++; if (done !== 1'b0 || bin_out !== V_BIN[v]) begin n_bad++; $display("FAIL conv_pulse_hold[%h]: got done=%b bin=%h want done=0 bin=%h", V_BCD[v], done, bin_out, V_BIN[v]); end
        end
    endtask

    task automatic test_error();
        int edges, bcyc;
        launch(20'h1A345);
        wait_done(edges, bcyc);
        n_cmp++; if (edges !== 2) begin n_bad++; $display("FAIL err_latency: got %0d want 2", edges); end
        n_cmp++; if (bcyc !== 2) begin n_bad++; $display("FAIL err_busy_cycles: got %0d want 2", bcyc); end
        n_cmp++; if (err !== 1'b1 || ovf !== 1'b0) begin n_bad++; $display("FAIL err_flags: got err=%b ovf=%b want err=1 ovf=0", err, ovf); end
        n_cmp++; if (bin_out !== 16'h0) begin n_bad++; $display("FAIL err_bin: got %h want 0000", bin_out); end
        launch(20'h00042);
        wait_done(edges, bcyc);
        n_cmp++; if (edges !== 18) begin n_bad++; $display("FAIL err_recover_latency: got %0d want 18", edges); end
        n_cmp++; if (err !== 1'b0 || bin_out !== 16'h002A) begin n_bad++; $display("FAIL err_recover: got err=%b bin=%h want err=0 bin=002a", err, bin_out); end
    endtask

    task automatic test_back_to_back();
        int done_edge, edges, bcyc, extra;
        done_edge = -1;
        launch(20'h00100);
        for (int i = 1; i <= 40 && done_edge < 0; i++) begin
            @(negedge clk);
            if (i == 4) begin start = 1'b1; bcd_in = 20'h00200; end
            if (i == 5) start = 1'b0;
            if (done === 1'b1) done_edge = i;
        end
        n_cmp++; if (done_edge !== 18) begin n_bad++; $display("FAIL b2b_ignored_latency: got %0d want 18", done_edge); end
        n_cmp++; if (bin_out !== 16'h0064) begin n_bad++; $display("FAIL b2b_first_bin: got %h want 0064", bin_out); end
        start = 1'b1; bcd_in = 20'h00007;
        @(negedge clk);
        start = 1'b0; bcd_in = 20'hFFFFF;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
        wait_done(edges, bcyc);
        n_cmp++; if (edges !== 18) begin n_bad++; $display("FAIL b2b_second_latency: got %0d want 18", edges); end
        n_cmp++; if (bin_out !== 16'h0007) begin n_bad++; $display("FAIL b2b_second_bin: got %h want 0007", bin_out); end
        extra = 0;
        repeat (25) begin @(negedge clk); if (done === 1'b1) extra++; end
        n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL b2b_extra_done: got %0d want 0", extra); end
    endtask

    task automatic test_reset_mid();
        int edges, bcyc, extra;
        launch(20'h12345);
        repeat (8) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({busy, done, ovf, err} !== 4'b0) begin n_bad++; $display("FAIL rstmid_flags: got %b want 0000", {busy, done, ovf, err}); end
        n_cmp++; if (bin_out !== 16'h0) begin n_bad++; $display("FAIL rstmid_bin: got %h want 0000", bin_out); end
        n_cmp++; if (state_dbg !== 2'd0) begin n_bad++; $display("FAIL rstmid_state: got %0d want 0", state_dbg); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (30) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) extra++; end
        n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d active cycles want 0", extra); end
        launch(20'h00999);
        wait_done(edges, bcyc);
        n_cmp++; if (edges !== 18) begin n_bad++; $display("FAIL rstmid_fresh_latency: got %0d want 18", edges); end
        n_cmp++; if (bin_out !== 16'h03E7 || ovf !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL rstmid_fresh_result: got bin=%h ovf=%b err=%b want 03e7 0 0", bin_out, ovf, err); end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_error();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
- Sequential converter that turns a 5-digit packed BCD value into a 16-bit unsigned binary value. It is the inverse of the binary-to-BCD path that feeds the seven-segment displays.
- It uses reverse double-dabble: shift right one bit per cycle, then subtract 3 from any digit that is 8 or more.
- It is used for decimal entry, such as switch or keypad presets loaded into the 16-bit counter.
- A start/busy/done handshake lets the control logic launch one conversion and collect the result.

Parameters:
- DIGITS, 5: number of packed BCD input digits (4 bits each).
- OUT_W, 16: width of the binary result.
- ITER, 17: number of shift iterations. Must be at least ceil(log2(10^DIGITS)); 17 for 5 digits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD, digit 0 in bits [3:0]; sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when results update.
- bin_out  output  OUT_W  converted value; holds until the next completion.
- ovf  output  1  value exceeds 2^OUT_W-1; bin_out saturates to all ones.
- err  output  1  an input digit was greater than 9; bin_out forced to 0.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state IDLE, busy=0, done=0, bin_out=0, ovf=0, err=0, iteration counter=0, work register=0.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - On an edge with start=1 (call it E0), capture bcd_in into the BCD half of the work register and clear the binary half. Set busy=1.
  - If any captured digit is greater than 9, go to FINISH with an err flag latched. Otherwise go to SHIFT with counter=0.
  - With start=0, stay in IDLE.
- SHIFT, once per edge:
  - Shift {bcd, bin} right by 1.
  - Then, in each 4-bit digit of the shifted BCD half, subtract 3 if the digit is 8 or more. All digits are corrected in parallel, in the same cycle.
  - Increment the counter. After ITER shifts (edge E_ITER), go to FINISH.
- FINISH, one edge:
  - Register the results and pulse done=1 for exactly one cycle. Set busy=0 and return to IDLE.
  - ovf=1 if the ITER-bit result is greater than 2^OUT_W-1. In that case bin_out=all ones; otherwise bin_out=result[OUT_W-1:0].
  - On error: err=1, ovf=0, bin_out=0.
  - err and ovf are otherwise cleared on each completion.
- Latency (valid input): done is high in the cycle after edge E(ITER+1); 18 edges after acceptance by default. busy is high from E0 to E(ITER+1).
- Latency (invalid input): done is high after edge E2. The validity check occurs at acceptance, then FINISH.
- start while busy: ignored and not queued; bcd_in changes during busy have no effect.
- start in the cycle done is high: accepted, because the block is already in IDLE. This gives back-to-back conversions with no dead cycle.
- Outputs bin_out, ovf and err change only in FINISH or on reset.
- Reset mid-conversion: immediate return to IDLE with all outputs at reset values; no done pulse is produced.
- Width rule: the work register is 4*DIGITS + ITER bits. Digit correction is 4-bit unsigned, with no borrow between digits.

Test Plan:
- Reset, then start with bcd_in=20'h00000 -> done after 18 edges, bin_out=16'h0000, ovf=0, err=0; busy high for exactly 18 cycles.
- bcd_in=20'h65535 -> bin_out=16'hFFFF, ovf=0, err=0. Then bcd_in=20'h01234 -> bin_out=16'h04D2.
- bcd_in=20'h65536 -> bin_out=16'hFFFF, ovf=1. Then bcd_in=20'h99999 -> bin_out=16'hFFFF, ovf=1.
- bcd_in=20'h1A345 -> err=1, bin_out=0, ovf=0, done high after edge E2. Then bcd_in=20'h00042 -> err=0, bin_out=16'h002A.
- Pulse start again at E5 during a conversion of 20'h00100 with bcd_in=20'h00200 -> ignored; a single done, bin_out=16'h0064. Then assert start in the done cycle with 20'h00007 -> accepted; second done 18 edges later with bin_out=16'h0007.
- Assert rst asynchronously mid-edge at cycle 9 of a conversion -> busy, done, bin_out, ovf and err go to 0 immediately; no done pulse afterwards. A fresh start after reset converts normally.
